// File: rtl/sr_pkg.sv
// Shared definitions for gated S/R/En latch controllers: state encoding and
// default phase widths.
package sr_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_HOLD  = 3'd3,
        ST_CHECK = 3'd4
    } sr_state_e;

    localparam int DEF_SETUP_W = 1;
    localparam int DEF_PULSE_W = 2;
    localparam int DEF_HOLD_W  = 2;
    localparam int DEF_CNT_W   = 4;

    // S/R carry the target value for the whole setup-pulse-hold window.
    function automatic logic drives_sr(sr_state_e st);
        return (st == ST_SETUP) || (st == ST_PULSE) || (st == ST_HOLD);
    endfunction

endpackage

// File: rtl/sr_latch_driver_sync_2ff.sv
// Generic 1-bit two-flop synchroniser with synchronous active-low reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/sr_latch_driver.sv
// Initiator for an external gated SR latch: converts a set-to-value request
// into a timed S/R/En sequence and verifies the result via Q readback.
module sr_latch_driver
    import sr_pkg::*;
#(
    parameter int SETUP_W = DEF_SETUP_W,
    parameter int PULSE_W = DEF_PULSE_W,
    parameter int HOLD_W  = DEF_HOLD_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    output logic req_ready,
    input  logic req_val,
    input  logic req_force,
    output logic S,
    output logic R,
    output logic En,
    input  logic Q_fb,
    output logic busy,
    output logic done,
    output logic fault,
    input  logic fault_clr,
    output logic exp_q,
    output logic known
);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_W - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_W - 1);

    sr_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             val_q, val_d;
    logic             s_q, s_d;
    logic             r_q, r_d;
    logic             en_q, en_d;
    logic             done_q, done_d;
    logic             fault_q, fault_d;
    logic             exp_q_q, exp_q_d;
    logic             known_q, known_d;
    logic             q_sync;

    sync_2ff u_q_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (Q_fb),
        .q     (q_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        val_d   = val_q;
        exp_q_d = exp_q_q;
        known_d = known_q;
        fault_d = fault_clr ? 1'b0 : fault_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    val_d = req_val;
                    if (known_q && (req_val == exp_q_q) && !req_force) begin
                        state_d = ST_CHECK;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_SETUP;
                        cnt_d   = SETUP_LD;
                    end
                end
            end
            ST_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = ST_PULSE;
                    cnt_d   = PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_CHECK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_CHECK: begin
                state_d = ST_IDLE;
                exp_q_d = val_q;
                known_d = 1'b1;
                // A new mismatch overrides a simultaneous clear.
                if (q_sync != val_q) begin
                    fault_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        s_d    = drives_sr(state_d) &&  val_d;
        r_d    = drives_sr(state_d) && !val_d;
        en_d   = (state_d == ST_PULSE);
        done_d = (state_d == ST_CHECK);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            val_q   <= 1'b0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            exp_q_q <= 1'b0;
            known_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            val_q   <= val_d;
            s_q     <= s_d;
            r_q     <= r_d;
            en_q    <= en_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            exp_q_q <= exp_q_d;
            known_q <= known_d;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign En        = en_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign exp_q     = exp_q_q;
    assign known     = known_q;
    assign busy      = (state_q != ST_IDLE);
    assign req_ready = (state_q == ST_IDLE);

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: directed table, corner sequences,
// a second instance with non-default widths, and randomized model checks.
module tb_sr_latch_driver;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_valid = 1'b0, req_val = 1'b0, req_force = 1'b0, fault_clr = 1'b0;
    logic req_ready, S, R, En, Q_fb, busy, done, fault, exp_q, known;
    logic stuck = 1'b0;
    logic lq = 1'b0;

    logic b_valid = 1'b0, b_val = 1'b0;
    logic b_ready, b_S, b_R, b_En, b_busy, b_done, b_fault, b_exp_q, b_known;
    logic b_lq = 1'b0;

    int checks = 0;
    int errors = 0;
    logic prev_s = 1'b0, prev_r = 1'b0, prev_en = 1'b0;

    always #5 clk = ~clk;

    // Behavioural level-sensitive SR latches on both driver outputs.
    always @* if (En)   begin if (S)   lq   = 1'b1; else if (R)   lq   = 1'b0; end
    always @* if (b_En) begin if (b_S) b_lq = 1'b1; else if (b_R) b_lq = 1'b0; end
    assign Q_fb = stuck ? 1'b0 : lq;

    sr_latch_driver dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_val(req_val), .req_force(req_force), .S(S), .R(R), .En(En),
        .Q_fb(Q_fb), .busy(busy), .done(done), .fault(fault),
        .fault_clr(fault_clr), .exp_q(exp_q), .known(known)
    );

    sr_latch_driver #(.SETUP_W(3), .PULSE_W(1), .HOLD_W(4), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_val(b_val), .req_force(1'b0), .S(b_S), .R(b_R), .En(b_En),
        .Q_fb(b_lq), .busy(b_busy), .done(b_done), .fault(b_fault),
        .fault_clr(1'b0), .exp_q(b_exp_q), .known(b_known)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Advance one cycle, then check the S/R/En invariants on the new outputs.
    task automatic step();
        @(posedge clk);
        #1;
        chk("s_and_r", {31'd0, S & R}, 32'd0);
        if (En && prev_en) begin
            chk("sr_stable_in_en", {30'd0, S, R}, {30'd0, prev_s, prev_r});
        end
        prev_s  = S;
        prev_r  = R;
        prev_en = En;
    endtask

    task automatic set_stuck(input logic v);
        stuck = v;
        repeat (3) step();
    endtask

    // One request on the main DUT; returns En cycle count, done cycle, S/R errors.
    task automatic run_req(input logic val, input logic frc, input logic clr_at_done,
                           output int en_cnt, output int done_cyc, output int sr_bad);
        req_val   = val;
        req_force = frc;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        req_val   = 1'($urandom);
        req_force = 1'($urandom);
        en_cnt = 0; done_cyc = 0; sr_bad = 0;
        for (int cyc = 1; cyc <= 30 && done_cyc == 0; cyc++) begin
            if (En) begin
                en_cnt++;
                if (S !== val || R !== !val) sr_bad++;
            end
            if (done) begin
                done_cyc = cyc;
                if (clr_at_done) fault_clr = 1'b1;
            end
            step();
        end
        fault_clr = 1'b0;
        chk("ready_after_done", {31'd0, req_ready}, 32'd1);
    endtask

    typedef struct {
        logic val; logic frc; logic stk;
        int exp_en; int exp_done; logic exp_fault; logic exp_expq;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int en_cnt, done_cyc, sr_bad;
        logic m_known, m_expq, m_fault, m_latch;

        vecs[0] = '{1'b1, 1'b0, 1'b0, 2, 6, 1'b0, 1'b1};  // first set pulses
        vecs[1] = '{1'b1, 1'b0, 1'b0, 0, 1, 1'b0, 1'b1};  // already set: skip
        vecs[2] = '{1'b1, 1'b1, 1'b0, 2, 6, 1'b0, 1'b1};  // forced pulse
        vecs[3] = '{1'b0, 1'b0, 1'b0, 2, 6, 1'b0, 1'b0};  // reset
        vecs[4] = '{1'b1, 1'b0, 1'b1, 2, 6, 1'b1, 1'b1};  // Q stuck 0: mismatch
        vecs[5] = '{1'b0, 1'b0, 1'b1, 2, 6, 1'b1, 1'b0};  // match, fault sticky

        repeat (2) step();
        chk("rst_S", {31'd0, S}, 32'd0);
        chk("rst_R", {31'd0, R}, 32'd0);
        chk("rst_En", {31'd0, En}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_exp_q", {31'd0, exp_q}, 32'd0);
        chk("rst_known", {31'd0, known}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        rst_n = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            if (stuck != vecs[i].stk) set_stuck(vecs[i].stk);
            run_req(vecs[i].val, vecs[i].frc, 1'b0, en_cnt, done_cyc, sr_bad);
            $display("vec %0d val=%0d force=%0d stuck=%0d en=%0d done=%0d fault=%0d exp_q=%0d",
                     i, vecs[i].val, vecs[i].frc, vecs[i].stk, en_cnt, done_cyc, fault, exp_q);
            chk("vec_en_cycles", en_cnt, vecs[i].exp_en);
            chk("vec_done_cycle", done_cyc, vecs[i].exp_done);
            chk("vec_sr_value", sr_bad, 0);
            chk("vec_fault", {31'd0, fault}, {31'd0, vecs[i].exp_fault});
            chk("vec_exp_q", {31'd0, exp_q}, {31'd0, vecs[i].exp_expq});
            chk("vec_known", {31'd0, known}, 32'd1);
        end

        // Clear on the same edge as a fresh mismatch: set wins.
        run_req(1'b1, 1'b0, 1'b1, en_cnt, done_cyc, sr_bad);
        $display("clr_with_mismatch done=%0d fault=%0d", done_cyc, fault);
        chk("clr_vs_set_fault", {31'd0, fault}, 32'd1);
        fault_clr = 1'b1;
        step();
        fault_clr = 1'b0;
        $display("clr_alone fault=%0d", fault);
        chk("clr_alone_fault", {31'd0, fault}, 32'd0);
        set_stuck(1'b0);

        // Reset in the middle of the enable pulse.
        req_val = 1'b0; req_force = 1'b0; req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        chk("mid_pulse_en_before", {31'd0, En}, 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        $display("reset_mid_pulse En=%0d S=%0d R=%0d ready=%0d known=%0d", En, S, R, req_ready, known);
        chk("mid_rst_En", {31'd0, En}, 32'd0);
        chk("mid_rst_SR", {30'd0, S, R}, 32'd0);
        chk("mid_rst_ready", {31'd0, req_ready}, 32'd1);
        chk("mid_rst_known", {31'd0, known}, 32'd0);
        run_req(1'b0, 1'b0, 1'b0, en_cnt, done_cyc, sr_bad);
        $display("post_reset req val=0 en=%0d done=%0d", en_cnt, done_cyc);
        chk("post_rst_pulses", en_cnt, 2);
        chk("post_rst_done", done_cyc, 6);

        // Back-to-back with req_valid held: 1, 0, 1.
        begin
            logic seq_v[3];
            int dcyc[3];
            int n = 0;
            int en_tot = 0;
            seq_v[0] = 1'b1; seq_v[1] = 1'b0; seq_v[2] = 1'b1;
            dcyc[0] = 0; dcyc[1] = 0; dcyc[2] = 0;
            sr_bad = 0;
            req_val = seq_v[0]; req_valid = 1'b1;
            step();
            for (int cyc = 1; cyc <= 40 && n < 3; cyc++) begin
                if (En) begin
                    en_tot++;
                    if (S !== seq_v[n] || R !== !seq_v[n]) sr_bad++;
                end
                if (done) begin
                    dcyc[n] = cyc;
                    n++;
                    if (n < 3) req_val = seq_v[n];
                    else req_valid = 1'b0;
                end
                step();
            end
            req_valid = 1'b0;
            $display("back_to_back done=%0d,%0d,%0d en=%0d exp_q=%0d", dcyc[0], dcyc[1], dcyc[2], en_tot, exp_q);
            chk("b2b_done0", dcyc[0], 6);
            chk("b2b_done1", dcyc[1], 13);
            chk("b2b_done2", dcyc[2], 20);
            chk("b2b_en_total", en_tot, 6);
            chk("b2b_sr_value", sr_bad, 0);
            chk("b2b_exp_q", {31'd0, exp_q}, 32'd1);
        end

        // Non-default widths on the second instance.
        begin
            int b_en = 0, b_first = 0, b_dc = 0;
            b_val = 1'b1; b_valid = 1'b1;
            step();
            b_valid = 1'b0;
            for (int cyc = 1; cyc <= 30 && b_dc == 0; cyc++) begin
                if (b_En) begin
                    b_en++;
                    if (b_first == 0) b_first = cyc;
                end
                if (b_done) b_dc = cyc;
                step();
            end
            $display("sweep en=%0d first_en=%0d done=%0d fault=%0d", b_en, b_first, b_dc, b_fault);
            chk("sweep_en_cycles", b_en, 1);
            chk("sweep_en_cycle", b_first, 4);
            chk("sweep_done_cycle", b_dc, 9);
            chk("sweep_fault", {31'd0, b_fault}, 32'd0);
            chk("sweep_exp_q", {31'd0, b_exp_q}, 32'd1);
        end

        // Randomized requests against a rule-level model.
        m_known = known; m_expq = exp_q; m_fault = fault; m_latch = lq;
        for (int t = 0; t < 40; t++) begin
            logic val, frc, stk, clr, pulse, obs;
            val = 1'($urandom_range(0, 1));
            frc = ($urandom_range(0, 3) == 0);
            stk = ($urandom_range(0, 4) == 0);
            clr = ($urandom_range(0, 5) == 0);
            if (stk != stuck) set_stuck(stk);
            if (clr) begin
                fault_clr = 1'b1;
                step();
                fault_clr = 1'b0;
                m_fault = 1'b0;
                chk("rnd_clr_fault", {31'd0, fault}, 32'd0);
            end
            pulse = !(m_known && val == m_expq && !frc);
            if (pulse) m_latch = val;
            obs = stk ? 1'b0 : m_latch;
            if (obs != val) m_fault = 1'b1;
            m_expq = val;
            m_known = 1'b1;
            run_req(val, frc, 1'b0, en_cnt, done_cyc, sr_bad);
            $display("rnd %0d val=%0d force=%0d stuck=%0d en=%0d done=%0d fault=%0d exp_q=%0d",
                     t, val, frc, stk, en_cnt, done_cyc, fault, exp_q);
            chk("rnd_en_cycles", en_cnt, pulse ? 2 : 0);
            chk("rnd_done_cycle", done_cyc, pulse ? 6 : 1);
            chk("rnd_sr_value", sr_bad, 0);
            chk("rnd_fault", {31'd0, fault}, {31'd0, m_fault});
            chk("rnd_exp_q", {31'd0, exp_q}, {31'd0, m_expq});
            chk("rnd_known", {31'd0, known}, 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Initiator side of the gated set/reset latch interface: turns a one-bit "set to value" request into a timed S/R/En sequence for an external level-sensitive SR latch.
- Each write is checked against the latch's Q readback, and a sticky fault is flagged on mismatch.
- Sits between control logic (valid/ready request port) and any S/R/En-gated latch in the design.

Parameters:
SETUP_W, 1, cycles S/R are driven with En low before the enable pulse (>=1)
PULSE_W, 2, cycles En is held high (>=1)
HOLD_W, 2, cycles S/R stay stable after En falls (>=2, covers Q_fb synchroniser latency)
CNT_W, 4, phase-counter width; must hold max(SETUP_W, PULSE_W, HOLD_W)-1

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  driver can accept a request
req_val  input  1  target latch value: 1 = set, 0 = reset
req_force  input  1  pulse even if latch already holds req_val
S  output  1  latch set drive
R  output  1  latch reset drive
En  output  1  latch enable
Q_fb  input  1  latch Q readback (asynchronous to clk)
busy  output  1  sequence in progress (state != IDLE)
done  output  1  one-cycle completion strobe
fault  output  1  sticky readback-mismatch flag
fault_clr  input  1  clears fault
exp_q  output  1  expected latch value
known  output  1  exp_q valid (at least one completed write since reset)

Behaviour:
- Reset is synchronous and active-low: rst_n low at a rising clk edge forces all state. One clock; everything is registered on the clk rising edge.
- Reset values: S=R=En=0, done=0, fault=0, exp_q=0, known=0, busy=0, req_ready=1, state=IDLE, counter=0.
- Q_fb passes through a 2-flop synchroniser (q_sync); only q_sync is used internally.
- Handshake: accept when req_valid && req_ready at an edge. req_ready = (state==IDLE). req_val and req_force are latched at accept.
- FSM states and transitions:
  - IDLE: S=R=En=0. On accept:
    - known && req_val==exp_q && !req_force -> CHECK (skip path; no pulse).
    - otherwise -> SETUP.
  - SETUP: S=val, R=~val, En=0, for SETUP_W cycles -> PULSE.
  - PULSE: S/R unchanged, En=1, for PULSE_W cycles -> HOLD.
  - HOLD: S/R unchanged, En=0, for HOLD_W cycles -> CHECK.
  - CHECK: one cycle. done=1, S=R=En=0. Compare q_sync with latched val. At end of cycle: exp_q<=val, known<=1, set fault on mismatch. -> IDLE.
- Latency (SETUP_W=1, PULSE_W=2, HOLD_W=2), accept at edge 0:
  - SETUP in cycle 1; En high in cycles 2-3; HOLD in cycles 4-5.
  - done high in cycle 6; req_ready high in cycle 7.
  - Skip path: done in cycle 1.
- Counter reloads on every state entry; phase length is exactly the parameter value.
- Invariants:
  - S&&R never 1.
  - En high only in PULSE.
  - S/R never change while En=1.
  - S/R/En are registered outputs; no combinational path from inputs.
- fault:
  - Sticky until fault_clr sampled high.
  - fault_clr and a new mismatch on the same edge -> fault stays 1 (set wins).
  - fault does not block further requests.
- Back-to-back requests: a request held in CHECK's following IDLE cycle is accepted then. Minimum one IDLE cycle between sequences.
- Reset mid-sequence (including during PULSE): the next edge returns to IDLE with En=0 and clears known. The external latch state is then unknown, so the next request always pulses.
- Inputs are ignored while busy; req_val and req_force changes after accept have no effect.

Decomposition:
- Shared package (sr_pkg): state encoding constants (IDLE, SETUP, PULSE, HOLD, CHECK, 3 bits) and default phase-width constants, for reuse by other latch controllers and the bench.
- One sub-module: sync_2ff (generic 1-bit two-flop synchroniser, synchronous active-low reset to 0), instantiated for Q_fb.

Test Plan:
- Set after reset: req_val=1 accepted at edge 0, bench latch model driven by S/R/En -> S=1/R=0 from cycle 1, En=1 cycles 2-3 only, done cycle 6, exp_q=1, known=1, fault=0.
- Skip path: after set, request req_val=1, req_force=0 -> no En pulse; done cycle 1, fault=0. Same request with req_force=1 -> full 6-cycle sequence.
- Fault: Q_fb stuck at 0, request set -> fault=1 from cycle 7 and stays through a following reset-to-0 request. fault_clr on the same edge as a second mismatch -> fault remains 1. fault_clr alone -> 0.
- Reset mid-PULSE: rst_n low in cycle 2 -> cycle 3 shows En=0, S=R=0, req_ready=1, known=0. Next req_val=0 request pulses despite exp_q=0.
- Back-to-back with req_valid held: alternating 1/0/1 requests -> each accepted one cycle after the previous done. S and R never simultaneously 1; S/R stable whenever En=1 (assertion).
- Parameter sweep SETUP_W=3, PULSE_W=1, HOLD_W=4 -> En high exactly 1 cycle (cycle 4), done in cycle 9.
